// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: load funct3 encodings, writeback FSM states, the
// mem->wb packet type and load legality/alignment helpers.
package rv32_pkg;

    localparam int unsigned WB_LOAD_TIMEOUT_DEFAULT = 255;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        WB_IDLE,
        WB_WAIT_LOAD
    } wb_state_e;

    typedef struct packed {
        logic        valid_opcode;
        logic        wb_enable;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
    } rv32_mem2wb_packet_t;

    function automatic logic load_is_legal(input logic [2:0] funct3);
        case (funct3)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    function automatic logic load_is_aligned(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3)
            F3_LH, F3_LHU: return !offset[0];
            F3_LW:         return offset == 2'b00;
            default:       return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword from an aligned memory word and
// sign- or zero-extends it according to the load funct3.
module load_align
    import rv32_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_offset,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        case (byte_offset)
            2'd0:    sel_byte = rdata[7:0];
            2'd1:    sel_byte = rdata[15:8];
            2'd2:    sel_byte = rdata[23:16];
            default: sel_byte = rdata[31:24];
        endcase
        sel_half = byte_offset[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_LB:   data = {{24{sel_byte[7]}}, sel_byte};
            F3_LH:   data = {{16{sel_half[15]}}, sel_half};
            F3_LW:   data = rdata;
            F3_LBU:  data = {24'd0, sel_byte};
            F3_LHU:  data = {16'd0, sel_half};
            default: data = 32'd0;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: accepts memory-stage results, waits for load data and drives
// the register-file write packet. Define WB_RETIRE_COUNTER_EN to add the instret port.
module writeback_stage
    import rv32_pkg::*;
#(
    parameter int unsigned LOAD_TIMEOUT = WB_LOAD_TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic                mem_valid_opcode,
    input  logic                mem_wb_en,
    input  logic [4:0]          mem_rd,
    input  logic [31:0]         mem_alu_result,
    input  logic                mem_is_load,
    input  logic [2:0]          mem_load_funct3,
    input  logic                dmem_rvalid,
    input  logic [31:0]         dmem_rdata,
    output rv32_mem2wb_packet_t writeback_packet,
    output logic                load_fault
`ifdef WB_RETIRE_COUNTER_EN
    ,
    output logic [63:0]         instret
`endif
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(LOAD_TIMEOUT - 1);

    wb_state_e           state, state_next;
    logic [15:0]         timeout_cnt, timeout_cnt_next;
    logic                cap_valid_opcode, cap_wb_en;
    logic [4:0]          cap_rd;
    logic [2:0]          cap_funct3;
    logic [1:0]          cap_offset;
    logic                accept;
    logic [31:0]         load_data;
    rv32_mem2wb_packet_t packet_next;
    logic                fault_next;

    assign mem_ready = (state == WB_IDLE);
    assign accept    = mem_valid && mem_ready;

    load_align u_load_align (
        .funct3      (cap_funct3),
        .byte_offset (cap_offset),
        .rdata       (dmem_rdata),
        .data        (load_data)
    );

    always_comb begin
        state_next       = state;
        timeout_cnt_next = timeout_cnt;
        packet_next      = '0;
        fault_next       = 1'b0;
        case (state)
            WB_IDLE: begin
                if (accept) begin
                    if (!mem_is_load) begin
                        packet_next.valid_opcode = mem_valid_opcode;
                        packet_next.wb_enable    = mem_wb_en && mem_valid_opcode && (mem_rd != 5'd0);
                        packet_next.wb_addr      = mem_rd;
                        packet_next.wb_data      = mem_alu_result;
                    end else if (!load_is_legal(mem_load_funct3) ||
                                 !load_is_aligned(mem_load_funct3, mem_alu_result[1:0])) begin
                        fault_next = 1'b1;
                    end else begin
                        state_next       = WB_WAIT_LOAD;
                        timeout_cnt_next = '0;
                    end
                end
            end
            WB_WAIT_LOAD: begin
                if (dmem_rvalid) begin
                    packet_next.valid_opcode = cap_valid_opcode;
                    packet_next.wb_enable    = cap_wb_en && cap_valid_opcode && (cap_rd != 5'd0);
                    packet_next.wb_addr      = cap_rd;
                    packet_next.wb_data      = load_data;
                    state_next               = WB_IDLE;
                end else if (timeout_cnt == TIMEOUT_LAST) begin
                    // Abandoned load retires nothing: packet stays all-zero.
                    fault_next = 1'b1;
                    state_next = WB_IDLE;
                end else begin
                    timeout_cnt_next = timeout_cnt + 16'd1;
                end
            end
            default: state_next = WB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state            <= WB_IDLE;
            timeout_cnt      <= '0;
            writeback_packet <= '0;
            load_fault       <= 1'b0;
            cap_valid_opcode <= 1'b0;
            cap_wb_en        <= 1'b0;
            cap_rd           <= '0;
            cap_funct3       <= '0;
            cap_offset       <= '0;
        end else begin
            state            <= state_next;
            timeout_cnt      <= timeout_cnt_next;
            writeback_packet <= packet_next;
            load_fault       <= fault_next;
            if (accept) begin
                cap_valid_opcode <= mem_valid_opcode;
                cap_wb_en        <= mem_wb_en;
                cap_rd           <= mem_rd;
                cap_funct3       <= mem_load_funct3;
                cap_offset       <= mem_alu_result[1:0];
            end
        end
    end

`ifdef WB_RETIRE_COUNTER_EN
    // Counts on the same edge the retiring packet is registered, so instret
    // already includes a packet in the cycle it is visible.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            instret <= '0;
        end else if (packet_next.valid_opcode) begin
            instret <= instret + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed cases plus randomized
// transactions compared every cycle against a per-cycle expectation timeline.
module tb_writeback_stage;
    import rv32_pkg::*;

    localparam int T     = 4;
    localparam int DEPTH = 8192;

    logic                clk = 1'b0;
    logic                resetn;
    logic                mem_valid;
    logic                mem_ready;
    logic                mem_valid_opcode;
    logic                mem_wb_en;
    logic [4:0]          mem_rd;
    logic [31:0]         mem_alu_result;
    logic                mem_is_load;
    logic [2:0]          mem_load_funct3;
    logic                dmem_rvalid;
    logic [31:0]         dmem_rdata;
    rv32_mem2wb_packet_t writeback_packet;
    logic                load_fault;
`ifdef WB_RETIRE_COUNTER_EN
    logic [63:0]         instret;
`endif

    writeback_stage #(.LOAD_TIMEOUT(T)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .mem_valid        (mem_valid),
        .mem_ready        (mem_ready),
        .mem_valid_opcode (mem_valid_opcode),
        .mem_wb_en        (mem_wb_en),
        .mem_rd           (mem_rd),
        .mem_alu_result   (mem_alu_result),
        .mem_is_load      (mem_is_load),
        .mem_load_funct3  (mem_load_funct3),
        .dmem_rvalid      (dmem_rvalid),
        .dmem_rdata       (dmem_rdata),
        .writeback_packet (writeback_packet),
        .load_fault       (load_fault)
`ifdef WB_RETIRE_COUNTER_EN
        ,
        .instret          (instret)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    rv32_mem2wb_packet_t exp_pkt   [DEPTH];
    logic                exp_fault [DEPTH];
    logic                exp_ready [DEPTH];

    int              tests_run     = 0;
    int              tests_failed  = 0;
    bit              check_en      = 1'b0;
    longint unsigned model_instret = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference load semantics: plain arithmetic on byte/halfword positions.
    function automatic bit model_faults(input logic [2:0] f3, input logic [31:0] addr);
        int unsigned off = addr % 32'd4;
        case (f3)
            3'd0, 3'd4: return 1'b0;
            3'd1, 3'd5: return (off % 2) != 0;
            3'd2:       return off != 0;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] word);
        int unsigned off = addr % 32'd4;
        int unsigned b   = (word >> (8 * off)) % 256;
        int unsigned h   = (word >> (16 * (off / 2))) % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? b - 256 : b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return word;
        endcase
    endfunction

    always @(negedge clk) begin
        if (check_en && resetn) begin
            if (cyc < DEPTH) begin
                if (exp_pkt[cyc].valid_opcode) model_instret++;
                checkOutput("mem_ready", 64'(mem_ready), 64'(exp_ready[cyc]));
                checkOutput("packet", 64'(writeback_packet), 64'(exp_pkt[cyc]));
                checkOutput("load_fault", 64'(load_fault), 64'(exp_fault[cyc]));
`ifdef WB_RETIRE_COUNTER_EN
                checkOutput("instret", instret, model_instret);
`endif
            end else begin
                checkOutput("cycle budget", 64'(cyc), 64'(DEPTH - 1));
            end
        end
    end

    task automatic randomFields();
        mem_valid_opcode = 1'($urandom_range(0, 1));
        mem_wb_en        = 1'($urandom_range(0, 1));
        mem_rd           = 5'($urandom_range(0, 31));
        mem_alu_result   = $urandom;
        mem_is_load      = 1'($urandom_range(0, 1));
        mem_load_funct3  = 3'($urandom_range(0, 7));
    endtask

    task automatic driveIdle();
        mem_valid = 1'b0;
        randomFields();
        dmem_rvalid = 1'($urandom_range(0, 1));
        dmem_rdata  = $urandom;
    endtask

    // Offers one instruction in the current cycle (stage known idle) and
    // records the outputs it must produce on the expectation timeline.
    task automatic applyStimulus(input bit is_load, input logic [2:0] f3, input logic [31:0] value,
                                 input logic [4:0] rd, input bit wb_en, input bit vo,
                                 input int rdelay, input logic [31:0] word);
        int c = cyc;
        rv32_mem2wb_packet_t p;
        mem_valid        = 1'b1;
        mem_is_load      = is_load;
        mem_load_funct3  = f3;
        mem_alu_result   = value;
        mem_rd           = rd;
        mem_wb_en        = wb_en;
        mem_valid_opcode = vo;
        dmem_rvalid      = 1'($urandom_range(0, 1));
        dmem_rdata       = $urandom;
        p.valid_opcode   = vo;
        p.wb_enable      = wb_en && vo && (rd != 5'd0);
        p.wb_addr        = rd;
        p.wb_data        = value;
        if (!is_load) begin
            exp_pkt[c + 1] = p;
            step();
        end else if (model_faults(f3, value)) begin
            exp_fault[c + 1] = 1'b1;
            step();
        end else begin
            int wait_len = (rdelay <= T) ? rdelay : T;
            for (int k = 1; k <= wait_len; k++) exp_ready[c + k] = 1'b0;
            if (rdelay <= T) begin
                p.wb_data = model_load(f3, value, word);
                exp_pkt[c + rdelay + 1] = p;
            end else begin
                exp_fault[c + T + 1] = 1'b1;
            end
            for (int k = 1; k <= wait_len; k++) begin
                step();
                mem_valid = 1'($urandom_range(0, 1));
                randomFields();
                dmem_rvalid = (k == rdelay);
                dmem_rdata  = (k == rdelay) ? word : $urandom;
            end
            step();
            mem_valid   = 1'b0;
            dmem_rvalid = (rdelay > T);
            dmem_rdata  = word;
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            exp_pkt[i]   = '0;
            exp_fault[i] = 1'b0;
            exp_ready[i] = 1'b1;
        end
        resetn = 1'b0;
        mem_valid = 1'b0; mem_valid_opcode = 1'b0; mem_wb_en = 1'b0; mem_rd = '0;
        mem_alu_result = '0; mem_is_load = 1'b0; mem_load_funct3 = '0;
        dmem_rvalid = 1'b0; dmem_rdata = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset packet", 64'(writeback_packet), 64'd0);
        checkOutput("reset fault", 64'(load_fault), 64'd0);
        checkOutput("reset ready", 64'(mem_ready), 64'd1);
`ifdef WB_RETIRE_COUNTER_EN
        checkOutput("reset instret", instret, 64'd0);
`endif
        resetn = 1'b1;
        step();
        checkOutput("ready after reset", 64'(mem_ready), 64'd1);
        check_en = 1'b1;

        // Non-load rd=5, 0xDEADBEEF
        applyStimulus(1'b0, 3'd0, 32'hDEADBEEF, 5'd5, 1'b1, 1'b1, 0, 32'd0);
        @(negedge clk);
        checkOutput("nonload packet", 64'(writeback_packet), 64'({1'b1, 1'b1, 5'd5, 32'hDEADBEEF}));
        driveIdle();
        step();
        @(negedge clk);
        checkOutput("nonload packet cleared", 64'(writeback_packet), 64'd0);

        // LB / LBU at byte 3 of 0x80FF0000, data three cycles after accept
        applyStimulus(1'b1, F3_LB, 32'h1003, 5'd7, 1'b1, 1'b1, 3, 32'h80FF_0000);
        @(negedge clk);
        checkOutput("LB data", 64'(writeback_packet.wb_data), 64'h0000_0000_FFFF_FF80);
        checkOutput("LB wb_enable", 64'(writeback_packet.wb_enable), 64'd1);
        applyStimulus(1'b1, F3_LBU, 32'h1003, 5'd7, 1'b1, 1'b1, 3, 32'h80FF_0000);
        @(negedge clk);
        checkOutput("LBU data", 64'(writeback_packet.wb_data), 64'h0000_0000_0000_0080);

        // Misaligned LH and LW
        applyStimulus(1'b1, F3_LH, 32'h1001, 5'd8, 1'b1, 1'b1, 1, 32'd0);
        @(negedge clk);
        checkOutput("LH misalign fault", 64'(load_fault), 64'd1);
        checkOutput("LH misalign wb_enable", 64'(writeback_packet.wb_enable), 64'd0);
        checkOutput("LH misalign ready", 64'(mem_ready), 64'd1);
        applyStimulus(1'b1, F3_LW, 32'h1002, 5'd8, 1'b1, 1'b1, 1, 32'd0);
        @(negedge clk);
        checkOutput("LW misalign fault", 64'(load_fault), 64'd1);
        checkOutput("LW misalign ready", 64'(mem_ready), 64'd1);

        // LW timeout, then a late response must be ignored
        applyStimulus(1'b1, F3_LW, 32'h1000, 5'd9, 1'b1, 1'b1, 99, 32'h1234_5678);
        @(negedge clk);
        checkOutput("timeout fault", 64'(load_fault), 64'd1);
        checkOutput("timeout ready", 64'(mem_ready), 64'd1);
        step();
        @(negedge clk);
        checkOutput("late rvalid ignored", 64'(writeback_packet), 64'd0);

        // Write to x0 is suppressed but still retires
        applyStimulus(1'b0, 3'd0, 32'h0000_1234, 5'd0, 1'b1, 1'b1, 0, 32'd0);
        @(negedge clk);
        checkOutput("x0 packet", 64'(writeback_packet), 64'({1'b1, 1'b0, 5'd0, 32'h0000_1234}));

        // Reset while waiting for load data
        check_en = 1'b0;
        applyStimulus(1'b0, 3'd0, 32'h0, 5'd1, 1'b0, 1'b0, 0, 32'd0);
        mem_valid = 1'b1; mem_is_load = 1'b1; mem_load_funct3 = F3_LW;
        mem_alu_result = 32'h2000; mem_rd = 5'd3; mem_wb_en = 1'b1; mem_valid_opcode = 1'b1;
        dmem_rvalid = 1'b0;
        step();
        mem_valid = 1'b0;
        @(negedge clk);
        checkOutput("ready during wait", 64'(mem_ready), 64'd0);
        resetn = 1'b0;
        model_instret = 0;
        #1;
        checkOutput("wait reset packet", 64'(writeback_packet), 64'd0);
        checkOutput("wait reset fault", 64'(load_fault), 64'd0);
        step();
        step();
        resetn = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
        step();
        dmem_rvalid = 1'b0;
        @(negedge clk);
        checkOutput("post reset ready", 64'(mem_ready), 64'd1);
        checkOutput("post reset packet", 64'(writeback_packet), 64'd0);
        checkOutput("post reset fault", 64'(load_fault), 64'd0);
`ifdef WB_RETIRE_COUNTER_EN
        checkOutput("post reset instret", instret, 64'd0);
`endif
        check_en = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            bit          ld;
            logic [2:0]  f3;
            logic [31:0] a;
            int          gaps;
            logic [2:0]  legal_f3 [5];
            legal_f3[0] = F3_LB; legal_f3[1] = F3_LH; legal_f3[2] = F3_LW;
            legal_f3[3] = F3_LBU; legal_f3[4] = F3_LHU;
            ld = ($urandom_range(0, 9) >= 4);
            if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
            else f3 = legal_f3[$urandom_range(0, 4)];
            a = $urandom;
            if (ld && $urandom_range(0, 3) != 0) begin
                if (f3 == F3_LH || f3 == F3_LHU) a[0] = 1'b0;
                if (f3 == F3_LW) a[1:0] = 2'b00;
            end
            applyStimulus(ld, f3, a, 5'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 7) != 0), $urandom_range(1, T + 2), $urandom);
            gaps = $urandom_range(0, 2);
            repeat (gaps) begin
                driveIdle();
                step();
            end
        end
        driveIdle();
        dmem_rvalid = 1'b0;
        repeat (3) step();

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter LOAD_TIMEOUT, default 255, max cycles spent in WAIT_LOAD before the load is abandoned (range 1..65535).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 resetn  input  1  asynchronous active-low reset.
REQ-004 mem_valid  input  1  memory-stage result offered this cycle.
REQ-005 mem_ready  output  1  stage can accept a result this cycle.
REQ-006 mem_valid_opcode  input  1  offered instruction is a legal opcode.
REQ-007 mem_wb_en  input  1  instruction writes rd.
REQ-008 mem_rd  input  5  destination register index.
REQ-009 mem_alu_result  input  32  result for non-load instructions; byte address for loads.
REQ-010 mem_is_load  input  1  instruction is a load.
REQ-011 mem_load_funct3  input  3  load width/sign: LB=000, LH=001, LW=010, LBU=100, LHU=101.
REQ-012 dmem_rvalid  input  1  load data returned this cycle.
REQ-013 dmem_rdata  input  32  raw aligned word from data memory.
REQ-014 writeback_packet  output  rv32_mem2wb_packet_t  valid_opcode, wb_enable, wb_addr, wb_data toward the register file.
REQ-015 load_fault  output  1  one-cycle pulse: misaligned load, illegal funct3 or load timeout.
REQ-016 instret  output  64  retired-instruction count (present only with WB_RETIRE_COUNTER_EN).

Function
REQ-017 FSM states IDLE and WAIT_LOAD; mem_ready SHALL be 1 only in IDLE.
REQ-018 Accept = mem_valid && mem_ready; fields are captured into internal registers on accept.
REQ-019 Non-load accepted at cycle N: writeback_packet is driven at N+1 for exactly one cycle; wb_data = mem_alu_result; FSM stays IDLE.
REQ-020 Legal, aligned load accepted at cycle N: FSM goes to WAIT_LOAD; dmem_rvalid is ignored at cycle N.
REQ-021 In WAIT_LOAD, dmem_rvalid at cycle M: packet is driven at M+1 with extracted data; FSM returns to IDLE at M+1.
REQ-022 Extraction uses the captured address bits [1:0]: LB/LBU select byte addr[1:0], LH/LHU select halfword addr[1]; signed forms sign-extend, unsigned forms zero-extend; LW passes the word.
REQ-023 Misaligned load (LH/LHU with addr[0]=1; LW with addr[1:0]!=0) or illegal funct3: no WAIT_LOAD; packet at N+1 with wb_enable=0, valid_opcode=0; load_fault pulses at N+1.
REQ-024 Timeout: if LOAD_TIMEOUT cycles elapse in WAIT_LOAD without dmem_rvalid, packet with wb_enable=0, valid_opcode=0 and a load_fault pulse occur on the next cycle; FSM returns to IDLE.
REQ-025 wb_enable = captured mem_wb_en && captured mem_valid_opcode && rd!=0; writes to x0 are always suppressed.
REQ-026 When no packet is being driven, all writeback_packet fields are 0.
REQ-027 dmem_rvalid while in IDLE is ignored (stale response).
REQ-028 Back-to-back non-loads at N and N+1 produce packets at N+1 and N+2 with no bubble.

Reset
REQ-029 On resetn low: FSM=IDLE, writeback_packet all 0, load_fault=0, timeout counter=0, instret=0, capture registers=0; mem_ready=1 immediately after resetn rises.
REQ-030 Reset during WAIT_LOAD abandons the load silently; no packet and no fault are emitted.

Configuration
REQ-031 Macro WB_RETIRE_COUNTER_EN defined: instret port exists and increments by 1 in every cycle a packet with valid_opcode=1 is driven, wrapping at 2^64.
REQ-032 Macro undefined: instret port and counter are absent; all other behaviour is identical.

Structure
REQ-033 Shared package rv32_pkg holds the funct3 load encodings, the wb FSM state enum and the LOAD_TIMEOUT default; rv32_mem2wb_packet_t is the existing package type.
REQ-034 Sub-module load_align (combinational byte/half select and sign/zero extension) is used for extraction.

Verification
REQ-035 Non-load rd=5, result 0xDEADBEEF accepted at cycle 10 -> packet at 11 with wb_addr=5, wb_data=0xDEADBEEF, wb_enable=1; all-zero packet at 12.
REQ-036 LB addr 0x1003, rdata 0x80FF_0000, rvalid 3 cycles after accept -> wb_data=0xFFFFFF80; LBU same stimulus -> 0x00000080; mem_ready=0 throughout the wait.
REQ-037 LH addr 0x1001 -> load_fault pulse, wb_enable=0, no WAIT_LOAD; LW addr 0x1002 -> same response.
REQ-038 LOAD_TIMEOUT=4, LW with no rvalid -> fault pulse and FSM IDLE after 4 wait cycles; rvalid arriving afterwards is ignored.
REQ-039 Non-load rd=0, mem_wb_en=1 -> wb_enable=0, valid_opcode=1; with WB_RETIRE_COUNTER_EN, instret increments by 1.
REQ-040 resetn asserted during WAIT_LOAD -> no packet or fault; mem_ready=1 after release; instret=0.
